oam_responder: RTL

//  Owns object attribute memory (OAM) storage and serves the object pipeline's

---
 rtl/oam_responder.sv | 94 +++++++++
 1 files changed

// File: rtl/oam_responder.sv
// OAM storage with a priority video port (four consecutive halfwords per read) and
// a CPU word port whose writes are posted through a one-entry buffer.
module oam_responder #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] OAMaddr,
    input  logic              readOAM,
    output logic [63:0]       OAMdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-2:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            r_state;
    logic [15:0]       r_mem [DEPTH];
    logic [ADDR_W-2:0] r_waddr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wbe;
    logic [63:0]       r_oam_data;
    logic              r_rvalid;
    logic [31:0]       r_rdata;

    logic [ADDR_W-1:0] w_a1, w_a2, w_a3;
    logic [ADDR_W-1:0] w_cpu_lo, w_cpu_hi, w_buf_lo, w_buf_hi;
    logic              w_accept;

    // Address arithmetic is ADDR_W wide, so the four-halfword window wraps at DEPTH.
    assign w_a1     = OAMaddr + ADDR_W'(1);
    assign w_a2     = OAMaddr + ADDR_W'(2);
    assign w_a3     = OAMaddr + ADDR_W'(3);
    assign w_cpu_lo = {cpu_addr, 1'b0};
    assign w_cpu_hi = {cpu_addr, 1'b1};
    assign w_buf_lo = {r_waddr, 1'b0};
    assign w_buf_hi = {r_waddr, 1'b1};

    // Video owns every cycle it asks for; the CPU only gets idle video cycles.
    assign cpu_ready = (r_state == EMPTY) && !readOAM;
    assign w_accept  = cpu_req && cpu_ready;

    assign OAMdata    = r_oam_data;
    assign cpu_rvalid = r_rvalid;
    assign cpu_rdata  = r_rdata;

    // NOTE: all state here is sequential, so every assignment uses <= to avoid
    // read/write ordering races between flops sampled in the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the memory is flop-based and must come up zeroed, so it is reset
            // explicitly; a RAM macro could not be cleared this way.
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_state    <= EMPTY;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_wbe      <= '0;
            r_oam_data <= '0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_rvalid <= 1'b0;
            if (readOAM)
                r_oam_data <= {r_mem[OAMaddr], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};

            if (r_state == EMPTY) begin
                if (w_accept && cpu_we) begin
                    r_waddr <= cpu_addr;
                    r_wdata <= cpu_wdata;
                    r_wbe   <= cpu_be;
                    r_state <= FULL;
                end else if (w_accept) begin
                    r_rvalid <= 1'b1;
                    r_rdata  <= {r_mem[w_cpu_hi], r_mem[w_cpu_lo]};
                end
            end else if (!readOAM) begin
                // Drain in the first video-idle cycle; disabled bytes keep their value.
                if (r_wbe[0]) r_mem[w_buf_lo][7:0]  <= r_wdata[7:0];
                if (r_wbe[1]) r_mem[w_buf_lo][15:8] <= r_wdata[15:8];
                if (r_wbe[2]) r_mem[w_buf_hi][7:0]  <= r_wdata[23:16];
                if (r_wbe[3]) r_mem[w_buf_hi][15:8] <= r_wdata[31:24];
                r_state <= EMPTY;
            end
        end
    end

endmodule
